bytecode_fetch_ctrl: RTL
========================

// Module: bytecode_fetch_ctrl
// PURPOSE
//  Sequences the bytecode ROM (1024 x 8, synchronous read, 1-cycle latency) and
//  delivers bytes in program order to the decoder over a valid/ready handshake.
//  Owns the fetch PC, handles taken jumps by squashing stale fetches, and signals
//  end of program. Sits between the bytecode ROM and the instruction decoder.
// PARAMETERS
//  DATA_W  8   bytecode width in bits
//  ADDR_W  10  ROM address width (1024 entries)
// PORTS
//  clk         in   1       single clock, all logic on posedge
//  rst         in   1       synchronous, active-high reset
//  start       in   1       pulse: begin fetching at pc 0 (accepted in IDLE/DONE only)
//  halt        in   1       pulse: abort fetch, return to IDLE
//  prog_len    in   ADDR_W+1 program length in bytes, sampled on accepted start
//  rom_addr    out  ADDR_W  ROM read address
//  rom_en      out  1       ROM read strobe; rom_data valid the cycle after
//  rom_data    in   DATA_W  ROM read data
//  byte_valid  out  1       byte_data/byte_pc valid
//  byte_ready  in   1       decoder accepts byte when valid&&ready
//  byte_data   out  DATA_W  bytecode byte
//  byte_pc     out  ADDR_W  address of byte_data
//  jmp_valid   in   1       taken jump/branch request (one-cycle pulse)
//  jmp_target  in   ADDR_W  jump destination
//  running     out  1       state is FETCH
//  done        out  1       state is DONE
//  fault       out  1       only with FETCH_BOUNDS_EN (tied 0 otherwise)
// BEHAVIOUR
//  - Reset: state IDLE; rom_en=0, rom_addr=0, byte_valid=0, byte_data=0, byte_pc=0,
//    running=0, done=0, fault=0; buffer empty, no fetch in flight.
//  - States: IDLE -start-> FETCH; FETCH -end condition-> DONE; DONE -start-> FETCH;
//    any -halt-> IDLE (halt beats start/jump); FETCH -bad jump-> FAULT (option).
//  - 2-entry FIFO holds returned bytes; output is FIFO head. issue_pc = next addr.
//  - Issue rule: rom_en=1 when FETCH, issue_pc<prog_len, and
//    count + inflight - pop < 2 (pop = byte_valid&&byte_ready). Sustains 1 byte/clk.
//  - Latency: start in cycle N -> rom_addr=0 at N+1 -> byte_valid at N+2.
//  - Handshake: byte_data/byte_pc stable while byte_valid&&!byte_ready.
//  - Jump in cycle N (FETCH): byte popped in N counts as consumed; FIFO flushed,
//    in-flight read squashed (its data dropped at N+1), issue_pc<=jmp_target;
//    rom_addr=target at N+1, byte_valid at N+2 with byte_pc=target.
//  - Jump while byte_valid=0 is legal; back-to-back jumps: latest wins.
//  - End condition: issue_pc==prog_len, FIFO empty, no inflight, no jmp_valid
//    that cycle -> DONE next cycle. prog_len=0: start goes FETCH then DONE at N+2.
//  - PC arithmetic: issue_pc is ADDR_W+1 bits so prog_len=1024 terminates; no wrap.
//  - jmp_valid ignored in IDLE/DONE; start ignored in FETCH.
//  - halt/rst mid-operation: FIFO cleared, inflight squashed, outputs to reset values.
// CONFIGURATION
//  FETCH_BOUNDS_EN defined: jump with jmp_target>=prog_len enters FAULT (fault=1,
//    byte_valid=0, no issue) until halt or rst; start ignored in FAULT.
//  Not defined: no range check; out-of-range jump fetches until issue_pc==prog_len
//    fails to hold, i.e. issues nothing and goes DONE once drained; fault=0.
// STRUCTURE
//  Package bytecode_pkg: DATA_W/ADDR_W constants, fetch state enum
//    (IDLE, FETCH, DONE, FAULT), byte_t typedef; shared with decoder.
//  One sub-module: fetch_fifo2 (2-entry FIFO of {pc,data}, push/pop/flush, count).
//  FSM, issue logic and squash flag live in bytecode_fetch_ctrl.
// TESTING
//  - Reset: rst high 2 cycles -> all outputs 0, rom_en=0, state IDLE.
//  - Stream: prog_len=4, ROM 0..3={10,A7,00,05}, ready=1 -> 4 bytes on cycles
//    N+2..N+5 pc 0..3, done=1 at N+7, no extra rom_en.
//  - Backpressure: ready toggles 1,0,0,1 -> no byte lost/duplicated, data held
//    while stalled, rom_en never makes count+inflight exceed 2.
//  - Jump: accept pc 2 with jmp_valid, target 8 -> next byte_pc=8 two cycles later;
//    pc 3 never presented.
//  - Halt: halt at mid-stream with inflight read -> IDLE next cycle, byte_valid=0;
//    restart start -> first byte pc 0.
//  - Bounds (FETCH_BOUNDS_EN): prog_len=16, jump to 20 -> fault=1, no rom_en until halt.

Source files
------------

// File: rtl/bytecode_pkg.sv
// Package: bytecode_pkg
// Purpose: Shared constants and types for the bytecode fetch path and decoder.
//   BC_DATA_W     bytecode width in bits
//   BC_ADDR_W     bytecode ROM address width
//   byte_t        one bytecode byte
//   fetch_state_t fetch controller state encoding (ST_IDLE/ST_FETCH/ST_DONE/ST_FAULT)
package bytecode_pkg;

    localparam int unsigned BC_DATA_W = 8;
    localparam int unsigned BC_ADDR_W = 10;

    typedef logic [BC_DATA_W-1:0] byte_t;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE  = 2'd0;
    localparam fetch_state_t ST_FETCH = 2'd1;
    localparam fetch_state_t ST_DONE  = 2'd2;
    localparam fetch_state_t ST_FAULT = 2'd3;

endpackage

// File: rtl/fetch_fifo2.sv
// Module: fetch_fifo2
// Purpose: 2-entry FIFO of {pc, data} pairs holding bytes returned by the ROM.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_flush            empty the FIFO (beats push/pop)
//   i_push             write {i_push_pc, i_push_data}
//   i_pop              drop the head entry
//   o_count            occupancy 0..2
//   o_head_pc/data     head entry (meaningful only when o_count != 0)
module fetch_fifo2
    import bytecode_pkg::*;
#(
    parameter int unsigned DATA_W = BC_DATA_W,
    parameter int unsigned ADDR_W = BC_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_pc,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [1:0]        o_count,
    output logic [ADDR_W-1:0] o_head_pc,
    output logic [DATA_W-1:0] o_head_data
);

    logic [ADDR_W-1:0] r_pc   [2];
    logic [DATA_W-1:0] r_data [2];
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_wr_ptr;

    // Write slot is rd_ptr + count (mod 2).
    assign w_wr_ptr = r_rd_ptr ^ r_count[0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
            r_pc[0]   <= '0;
            r_pc[1]   <= '0;
            r_data[0] <= '0;
            r_data[1] <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_pc[w_wr_ptr]   <= i_push_pc;
                r_data[w_wr_ptr] <= i_push_data;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_count     = r_count;
    assign o_head_pc   = r_pc[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];

endmodule

// File: rtl/bytecode_fetch_ctrl.sv
// Module: bytecode_fetch_ctrl
// Purpose: Sequences a synchronous bytecode ROM (1-cycle read latency) and delivers
//   bytes in program order to the decoder over valid/ready. Owns the fetch PC,
//   squashes stale fetches on taken jumps and signals end of program.
// Configuration: define FETCH_BOUNDS_EN to trap jumps with target >= prog_len in a
//   FAULT state (o_fault=1) until halt/reset; otherwise no range check, o_fault=0.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_start, i_halt           start pulse (IDLE/DONE only), abort pulse (any state)
//   i_prog_len                program length in bytes, sampled on accepted start
//   o_rom_addr, o_rom_en      ROM read request; i_rom_data valid the next cycle
//   o_byte_valid/i_byte_ready byte handshake to the decoder
//   o_byte_data, o_byte_pc    byte and its address
//   i_jmp_valid, i_jmp_target taken jump pulse and destination
//   o_running, o_done         state is FETCH / DONE
//   o_fault                   state is FAULT (bounds option only)
module bytecode_fetch_ctrl
    import bytecode_pkg::*;
#(
    parameter int unsigned DATA_W = BC_DATA_W,
    parameter int unsigned ADDR_W = BC_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_halt,
    input  logic [ADDR_W:0]   i_prog_len,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic              o_rom_en,
    input  logic [DATA_W-1:0] i_rom_data,
    output logic              o_byte_valid,
    input  logic              i_byte_ready,
    output logic [DATA_W-1:0] o_byte_data,
    output logic [ADDR_W-1:0] o_byte_pc,
    input  logic              i_jmp_valid,
    input  logic [ADDR_W-1:0] i_jmp_target,
    output logic              o_running,
    output logic              o_done,
    output logic              o_fault
);

    fetch_state_t      r_state;
    logic [ADDR_W:0]   r_issue_pc;
    logic [ADDR_W:0]   r_prog_len;
    // Set when the read issued last cycle is still wanted; clearing it squashes
    // the returning data.
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;

    fetch_state_t      w_state_nxt;
    logic [ADDR_W:0]   w_issue_pc_nxt;
    logic [ADDR_W:0]   w_prog_len_nxt;
    logic              w_inflight_nxt;

    logic [1:0]        w_fifo_count;
    logic [ADDR_W-1:0] w_head_pc;
    logic [DATA_W-1:0] w_head_data;
    logic              w_fifo_empty;
    logic              w_fetch;
    logic              w_jmp;
    logic              w_pop;
    logic              w_fifo_push;
    logic              w_fifo_pop;
    logic              w_flush;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic              w_end;
    logic [ADDR_W-1:0] w_out_pc;
    logic [DATA_W-1:0] w_out_data;

    assign w_fifo_empty = (w_fifo_count == 2'd0);
    assign w_fetch      = (r_state == ST_FETCH);
    assign w_jmp        = w_fetch && i_jmp_valid && !i_halt;

    // Output is the FIFO head, or the byte arriving from the ROM when the FIFO is
    // empty, so a fresh read reaches the decoder the cycle its data returns.
    assign o_byte_valid = !w_fifo_empty || r_inflight;
    assign w_out_pc     = w_fifo_empty ? r_inflight_pc : w_head_pc;
    assign w_out_data   = w_fifo_empty ? i_rom_data : w_head_data;
    assign w_pop        = o_byte_valid && i_byte_ready;

    // Arriving byte is buffered unless it goes straight through to the decoder.
    assign w_fifo_push = r_inflight && !(w_fifo_empty && w_pop);
    assign w_fifo_pop  = w_pop && !w_fifo_empty;
    assign w_flush     = i_halt || w_jmp;

    // Bytes held after this cycle, before any new issue; pop implies occupancy >= 1.
    assign w_occ   = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = w_fetch && (r_issue_pc < r_prog_len) && (w_occ < 3'd2);
    // ">=" also drains to DONE after an unchecked jump past the program end.
    assign w_end   = (r_issue_pc >= r_prog_len) && w_fifo_empty && !r_inflight;

    always_comb begin
        w_state_nxt    = r_state;
        w_issue_pc_nxt = r_issue_pc + {{ADDR_W{1'b0}}, w_issue};
        w_prog_len_nxt = r_prog_len;
        w_inflight_nxt = w_issue;
        if (i_halt) begin
            w_state_nxt    = ST_IDLE;
            w_issue_pc_nxt = '0;
            w_inflight_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        w_state_nxt    = ST_FETCH;
                        w_issue_pc_nxt = '0;
                        w_prog_len_nxt = i_prog_len;
                    end
                end
                ST_FETCH: begin
                    if (w_jmp) begin
                        w_issue_pc_nxt = {1'b0, i_jmp_target};
                        w_inflight_nxt = 1'b0;
`ifdef FETCH_BOUNDS_EN
                        if ({1'b0, i_jmp_target} >= r_prog_len) begin
                            w_state_nxt = ST_FAULT;
                        end
`endif
                    end else if (w_end) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                default: begin
                    // FAULT: held until halt or reset.
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_issue_pc    <= '0;
            r_prog_len    <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_issue_pc    <= w_issue_pc_nxt;
            r_prog_len    <= w_prog_len_nxt;
            r_inflight    <= w_inflight_nxt;
            r_inflight_pc <= r_issue_pc[ADDR_W-1:0];
        end
    end

    fetch_fifo2 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (w_flush),
        .i_push      (w_fifo_push),
        .i_push_pc   (r_inflight_pc),
        .i_push_data (i_rom_data),
        .i_pop       (w_fifo_pop),
        .o_count     (w_fifo_count),
        .o_head_pc   (w_head_pc),
        .o_head_data (w_head_data)
    );

    assign o_rom_en    = w_issue;
    assign o_rom_addr  = w_issue ? r_issue_pc[ADDR_W-1:0] : '0;
    assign o_byte_data = o_byte_valid ? w_out_data : '0;
    assign o_byte_pc   = o_byte_valid ? w_out_pc : '0;
    assign o_running   = w_fetch;
    assign o_done      = (r_state == ST_DONE);
`ifdef FETCH_BOUNDS_EN
    assign o_fault     = (r_state == ST_FAULT);
`else
    assign o_fault     = 1'b0;
`endif

endmodule
